// File: rtl/led_fx_pkg.sv
// led_fx_pkg: shared mode encodings, register map and brightness constants for the LED effects stage
package led_fx_pkg;
    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_BRIGHT = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;
    localparam logic [7:0] BRIGHT_FULL = 8'hFF;
endpackage

// File: rtl/system_0_led_fx_if.sv
// system_0_led_fx_if: zero-wait-state Avalon-MM slave bus for the LED effects configuration registers
interface system_0_led_fx_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/system_0_led_fx_tick.sv
// system_0_led_fx_tick: prescaler counting 0..period, one-clk tick on the terminal count
module system_0_led_fx_tick (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] period,
    input  logic        clr,
    output logic        tick
);
    logic [23:0] cnt;
    // a clear suppresses the tick so a reconfiguration always restarts a full interval
    assign tick = !clr && cnt == period;
    // count up, wrapping on tick or restarting on clear
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= (clr || tick) ? '0 : cnt + 24'd1;
    end
endmodule

// File: rtl/system_0_led_fx.sv
// system_0_led_fx: LED effects (direct/blink/rotate/bounce) with global PWM brightness behind an Avalon-MM slave
module system_0_led_fx
    import led_fx_pkg::*;
#(
    parameter int          WIDTH          = 8,
    parameter logic [23:0] PERIOD_DEFAULT = 24'd4999999
) (
    input  logic                 clk,
    input  logic                 reset,
    system_0_led_fx_if.slave     bus,
    input  logic [WIDTH-1:0]     pattern_in,
    output logic [WIDTH-1:0]     led_out
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
    mode_t            mode;
    logic [7:0]       bright;
    logic [23:0]      period;
    logic             wr, ctrl_wr, per_wr, tick, on, phase, dir;
    logic [WIDTH-1:0] sreg, pat_q, frame, frame_d;
    logic [PW-1:0]    pos;
    logic [7:0]       pwm_cnt;
    assign wr      = bus.chipselect && !bus.write_n;
    assign ctrl_wr = wr && bus.address == ADDR_CTRL;
    assign per_wr  = wr && bus.address == ADDR_PERIOD;
    assign on      = (bright == BRIGHT_FULL) || (pwm_cnt < bright);
    system_0_led_fx_tick u_tick (
        .clk    (clk),
        .reset  (reset),
        .period (period),
        .clr    (ctrl_wr || per_wr),
        .tick   (tick)
    );
    // register readback; STATUS mirrors the live LED drive
    always_comb
        bus.readdata = bus.address == ADDR_CTRL   ? 32'(mode)   :
                       bus.address == ADDR_BRIGHT ? 32'(bright) :
                       bus.address == ADDR_PERIOD ? 32'(period) : 32'(led_out);
    // configuration registers; STATUS is read-only
    always_ff @(posedge clk) begin
        if (reset) begin
            mode   <= MODE_DIRECT;
            bright <= BRIGHT_FULL;
            period <= PERIOD_DEFAULT;
        end else if (wr) begin
            if (bus.address == ADDR_CTRL)   mode   <= mode_t'(bus.writedata[1:0]);
            if (bus.address == ADDR_BRIGHT) bright <= bus.writedata[7:0];
            if (bus.address == ADDR_PERIOD) period <= bus.writedata[23:0];
        end
    end
    // effect result for the current mode, registered into frame below
    always_comb
        frame_d = mode == MODE_DIRECT ? pattern_in :
                  mode == MODE_BLINK  ? (phase ? '0 : pattern_in) :
                  mode == MODE_ROTATE ? sreg : WIDTH'(1) << pos;
    // effect state: blink phase, rotate register (reload beats tick), bounce position reflecting at the ends
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= 1'b0;
            sreg  <= '0;
            pat_q <= '0;
            pos   <= '0;
            dir   <= 1'b0;
            frame <= '0;
        end else begin
            pat_q <= pattern_in;
            frame <= frame_d;
            phase <= ctrl_wr ? 1'b0 : phase ^ tick;
            if (ctrl_wr || pattern_in != pat_q)
                sreg <= pattern_in;
            else if (tick)
                sreg <= {sreg[WIDTH-2:0], sreg[WIDTH-1]};
            if (ctrl_wr) begin
                pos <= '0;
                dir <= 1'b0;
            end else if (tick) begin
                pos <= dir ? (pos == '0 ? PW'(1) : pos - PW'(1)) : (pos == POS_MAX ? POS_MAX - PW'(1) : pos + PW'(1));
                dir <= pos == POS_MAX ? 1'b1 : pos == '0 ? 1'b0 : dir;
            end
        end
    end
    // free-running PWM counter and gated LED drive
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            led_out <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            led_out <= frame & {WIDTH{on}};
        end
    end
endmodule

// File: tb/tb_system_0_led_fx.sv
// tb_system_0_led_fx: directed stimulus with a cycle model and hand-computed expectations for system_0_led_fx
module tb_system_0_led_fx;
    localparam logic [23:0] PDEF = 24'd4999999;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pattern_in = 8'h00;
    logic [7:0] led_out;
    int         errors = 0;
    int         checks = 0;
    system_0_led_fx_if bus();
    system_0_led_fx #(.WIDTH(8), .PERIOD_DEFAULT(PDEF)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pattern_in (pattern_in),
        .led_out    (led_out)
    );
    always #5 clk = ~clk;
    // model state: register contents, tick counter, blink phase, rotate value, bounce step index, pipeline
    logic [1:0] m_mode;
    logic [7:0] m_bright, m_frame, m_led, m_sreg, m_pat_q, m_pwm;
    logic       m_phase;
    int         m_cnt, m_period, m_k;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int bounce_pos(input int k);
        return k < 8 ? k : 14 - k;
    endfunction
    function automatic logic [31:0] exp_rd();
        case (bus.address)
            2'd0:    return {30'b0, m_mode};
            2'd1:    return {24'b0, m_bright};
            2'd2:    return 32'(m_period);
            default: return {24'b0, m_led};
        endcase
    endfunction
    task automatic model_step();
        logic       wr, cw, pw, tk;
        logic [7:0] nf;
        if (reset) begin
            m_mode = 0; m_bright = 8'hFF; m_period = int'(PDEF); m_cnt = 0;
            m_phase = 0; m_sreg = 0; m_k = 0; m_pwm = 0; m_frame = 0; m_led = 0; m_pat_q = 0;
        end else begin
            wr = bus.chipselect && !bus.write_n;
            cw = wr && bus.address == 2'd0;
            pw = wr && bus.address == 2'd2;
            tk = !(cw || pw) && m_cnt == m_period;
            m_cnt = (cw || pw || tk) ? 0 : m_cnt + 1;
            case (m_mode)
                2'd0:    nf = pattern_in;
                2'd1:    nf = m_phase ? 8'h00 : pattern_in;
                2'd2:    nf = m_sreg;
                default: nf = 8'h01 << bounce_pos(m_k);
            endcase
            m_led = m_frame & ((m_bright == 8'hFF || m_pwm < m_bright) ? 8'hFF : 8'h00);
            m_frame = nf;
            if (cw) m_phase = 0;
            else if (tk) m_phase = !m_phase;
            if (cw || pattern_in != m_pat_q) m_sreg = pattern_in;
            else if (tk) m_sreg = {m_sreg[6:0], m_sreg[7]};
            m_k = cw ? 0 : tk ? (m_k + 1) % 14 : m_k;
            m_pat_q = pattern_in;
            m_pwm = m_pwm + 8'd1;
            if (wr && bus.address == 2'd0) m_mode = bus.writedata[1:0];
            if (wr && bus.address == 2'd1) m_bright = bus.writedata[7:0];
            if (wr && bus.address == 2'd2) m_period = int'(bus.writedata[23:0]);
        end
    endtask
    // every cycle: advance the model on the edge, compare outputs just after it
    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        check("led_out", {24'b0, led_out}, {24'b0, m_led});
        check("readdata", bus.readdata, exp_rd());
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0;
    endtask
    initial begin
        int n;
        logic [7:0] exp8;
        int bpos [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
        cyc(3);
        check("reset led", {24'b0, led_out}, 32'h0);
        bus.address = 2'd0; #1 check("reset ctrl", bus.readdata, 32'h0);
        bus.address = 2'd1; #1 check("reset bright", bus.readdata, 32'hFF);
        bus.address = 2'd2; #1 check("reset period", bus.readdata, 32'h004C4B3F);
        bus.address = 2'd3; #1 check("reset status", bus.readdata, 32'h0);
        bus.address = 2'd0;
        reset = 1'b0;
        cyc(2);
        pattern_in = 8'hA5;
        cyc(1); check("direct +1", {24'b0, led_out}, 32'h00);
        cyc(1); check("direct +2", {24'b0, led_out}, 32'hA5);
        pattern_in = 8'hFF;
        wr_reg(2'd1, 32'd64);
        cyc(4);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out == 8'hFF) n++;
            cyc(1);
        end
        check("pwm 64/256", 32'(n), 32'd64);
        wr_reg(2'd1, 32'd0);
        cyc(4);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out != 8'h00) n++;
            cyc(1);
        end
        check("pwm dark", 32'(n), 32'd0);
        wr_reg(2'd1, 32'd255);
        pattern_in = 8'h0F;
        wr_reg(2'd2, 32'd3);
        wr_reg(2'd0, 32'd1);
        for (int i = 0; i < 22; i++) begin
            exp8 = (i < 2 || ((i - 2) / 4) % 2 == 0) ? 8'h0F : 8'h00;
            check("blink", {24'b0, led_out}, {24'b0, exp8});
            cyc(1);
        end
        pattern_in = 8'h81;
        wr_reg(2'd2, 32'd0);
        wr_reg(2'd0, 32'd2);
        cyc(2); check("rotate 0", {24'b0, led_out}, 32'h81);
        cyc(1); check("rotate 1", {24'b0, led_out}, 32'h03);
        cyc(1); check("rotate 2", {24'b0, led_out}, 32'h06);
        pattern_in = 8'h01;
        cyc(1); check("rotate 3", {24'b0, led_out}, 32'h0C);
        cyc(1); check("rotate 4", {24'b0, led_out}, 32'h18);
        cyc(1); check("rotate reload", {24'b0, led_out}, 32'h01);
        cyc(1); check("rotate after reload", {24'b0, led_out}, 32'h02);
        wr_reg(2'd0, 32'd3);
        cyc(2);
        for (int j = 0; j < 16; j++) begin
            exp8 = 8'h01 << bpos[j];
            check("bounce", {24'b0, led_out}, {24'b0, exp8});
            cyc(1);
        end
        reset = 1'b1;
        cyc(1);
        check("mid reset led", {24'b0, led_out}, 32'h0);
        check("mid reset ctrl", bus.readdata, 32'h0);
        reset = 1'b0;
        pattern_in = 8'h3C;
        cyc(1); check("post reset +1", {24'b0, led_out}, 32'h00);
        cyc(1); check("post reset direct", {24'b0, led_out}, 32'h3C);
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
